// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  MemReadM_i;
  logic                  MemWriteM_i;
  logic [ADDR_WIDTH-1:0] MemAddr_i;
  logic [DATA_WIDTH-1:0] WriteDataM_i;
  logic [DATA_WIDTH-1:0] ReadDataM_o;
  logic                  mem_stall_o;
  logic                  done_o;
  logic                  err_o;

  // Handshake: a request (MemReadM_i | MemWriteM_i) is taken only while the responder is idle;
  // the master must hold strobes, address and data stable until the cycle done_o is high,
  // and mem_stall_o stays high from the request cycle until that completion cycle.
  modport master (
    output MemReadM_i, MemWriteM_i, MemAddr_i, WriteDataM_i,
    input  ReadDataM_o, mem_stall_o, done_o, err_o
  );

  modport slave (
    input  MemReadM_i, MemWriteM_i, MemAddr_i, WriteDataM_i,
    output ReadDataM_o, mem_stall_o, done_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle 2**ADDR_WIDTH x DATA_WIDTH data memory with wait states, pipeline stall,
// completion pulse and a sticky flag for conflicting read/write strobes.
module dmem_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state, nextState;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] addrLatch;
  logic [DATA_WIDTH-1:0] wdataLatch;
  logic                  isWrite;
  logic [DATA_WIDTH-1:0] readData;
  logic                  errFlag;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  req;

  assign req      = bus.MemReadM_i | bus.MemWriteM_i;
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req) nextState = ACCESS;
      ACCESS:  if (cnt == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Stall in IDLE follows the request combinationally so the pipeline freezes in the request cycle.
  always_comb begin
    bus.mem_stall_o = 1'b0;
    bus.done_o      = 1'b0;
    case (state)
      IDLE:    bus.mem_stall_o = req;
      ACCESS:  bus.mem_stall_o = 1'b1;
      DONE:    bus.done_o      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      addrLatch  <= '0;
      wdataLatch <= '0;
      isWrite    <= 1'b0;
      readData   <= '0;
      errFlag    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addrLatch  <= bus.MemAddr_i;
            wdataLatch <= bus.WriteDataM_i;
            // A conflicting request is executed as a write and remembered until reset.
            isWrite    <= bus.MemWriteM_i;
            cnt        <= CNT_WIDTH'(WAIT_CYCLES - 1);
            if (bus.MemReadM_i && bus.MemWriteM_i) errFlag <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (isWrite) begin
            mem[addrLatch] <= wdataLatch;
          end else begin
            readData <= mem[addrLatch];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ReadDataM_o = readData;
  assign bus.err_o       = errFlag;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 16-bit pipelined processor. It sits on the MEM-stage data-memory interface: it takes the address, write data and read/write strobes, and returns read data.
- It models a multi-cycle memory: a parameterised number of wait states, with a stall output that freezes the pipeline until the access completes.
- It holds the 256 x 16 data array and flags illegal requests.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 8, address width; the array has 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states per access; legal range 1..15.
- CNT_WIDTH, 4, wait-counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MemReadM_i  input  1  read request from the MEM stage.
- MemWriteM_i  input  1  write request from the MEM stage.
- MemAddr_i  input  ADDR_WIDTH  word address.
- WriteDataM_i  input  DATA_WIDTH  store data.
- ReadDataM_o  output  DATA_WIDTH  registered load data; holds its value until the next read completes.
- mem_stall_o  output  1  pipeline stall request (drives stall_MEM_WB and upstream stalls).
- done_o  output  1  one-cycle pulse in the completion cycle.
- err_o  output  1  sticky flag: read and write were asserted together.

Behaviour:
- Reset (synchronous, active-high) sets:
  - FSM to IDLE, wait counter to 0;
  - ReadDataM_o=0, done_o=0, err_o=0, mem_stall_o=0;
  - every array word to 0 (sequential loop).
- Request: req = MemReadM_i | MemWriteM_i. The requester holds address, data and strobes stable from the request cycle through the DONE cycle.
- FSM states and transitions:
  - IDLE: mem_stall_o = req (combinational). If req: latch addr, wdata and op; load cnt = WAIT_CYCLES-1; go to ACCESS. Otherwise stay.
  - ACCESS: mem_stall_o=1. If cnt!=0: cnt decrements, stay. If cnt==0, on that edge:
    - write op: array[addr] <= wdata;
    - read op: ReadDataM_o <= array[addr];
    - go to DONE.
  - DONE: mem_stall_o=0, done_o=1. The pipeline advances at the end of this cycle. Go to IDLE unconditionally; the still-asserted request is not re-accepted.
- Latency: mem_stall_o is high for exactly WAIT_CYCLES+1 cycles per access. Read data is valid in DONE, WAIT_CYCLES+1 cycles after the request cycle. Back-to-back requests are accepted at a rate of one per WAIT_CYCLES+2 cycles.
- Simultaneous MemReadM_i and MemWriteM_i in IDLE: treated as a write, err_o set; err_o is cleared only by rst.
- Inputs changing during ACCESS or DONE are ignored; the latched copies are used.
- ReadDataM_o is unchanged by writes and by reads that have not yet completed.
- Read-after-write to the same address in the next access returns the new data (the write commits before DONE).
- Address wrap: none. The full 8-bit address indexes the array directly; 0xFF is valid.
- Reset mid-operation (rst in ACCESS): access aborted, no array write, next cycle IDLE with mem_stall_o=0. The array is zeroed by that reset.
- Reset in DONE: the write has already committed but is then cleared by the array reset.

Test Plan:
- Reset, then idle with no strobes -> mem_stall_o=0, done_o=0, ReadDataM_o=0x0000, err_o=0.
- WAIT_CYCLES=2; write 0xBEEF to addr 0x12 in cycle T0 -> mem_stall_o high T0–T2, done_o=1 at T3. Then read 0x12 -> ReadDataM_o=0xBEEF at its DONE cycle, stall again 3 cycles.
- Write 0x1234 to 0xFF, then write 0x5678 to 0x00, read 0xFF -> 0x1234; read 0x00 -> 0x5678. Each access starts 4 cycles after the previous one with no re-trigger in DONE.
- Read and write asserted together, addr 0x40, data 0xA5A5 -> err_o=1 (sticky); read 0x40 returns 0xA5A5; err_o stays 1 until rst.
- Start write 0x7777 to 0x20, assert rst in the first ACCESS cycle -> mem_stall_o=0 next cycle; later read 0x20 returns 0x0000.
- Change MemAddr_i from 0x30 to 0x31 during ACCESS of a read of 0x30 (array[0x30]=0x0A0A, array[0x31]=0x0B0B) -> ReadDataM_o=0x0A0A.
